// File: rtl/cpu_ctrl_pkg.sv
// Shared control-word layout for the ID-stage control unit and the ctrl_pipe stage registers.
package cpu_ctrl_pkg;

    localparam int CW = 11;
    localparam int RW = 5;

    localparam int CTRL_ALUSRC   = 10;
    localparam int CTRL_MEMTOREG = 9;
    localparam int CTRL_REGWR_HI = 8;
    localparam int CTRL_REGWR_LO = 7;
    localparam int CTRL_MEMREAD  = 6;
    localparam int CTRL_MEMWRITE = 5;
    localparam int CTRL_BRANCH   = 4;
    localparam int CTRL_ALUOP_HI = 3;
    localparam int CTRL_ALUOP_LO = 2;
    localparam int CTRL_RS1FPU   = 1;
    localparam int CTRL_RS2FPU   = 0;

    localparam logic [1:0] REGWRITE_NONE = 2'b00;
    localparam logic [1:0] REGWRITE_INT  = 2'b01;
    localparam logic [1:0] REGWRITE_FP   = 2'b10;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_FPU   = 2'b11
    } alu_op_e;

    localparam logic [CW-1:0] CTRL_NOP = '0;

    function automatic logic [1:0] regwrite_of(input logic [CW-1:0] cw);
        return cw[CTRL_REGWR_HI:CTRL_REGWR_LO];
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline register holding {ctrl, rd}; hold wins over clear, clear loads a nop.
module ctrl_stage_reg
    import cpu_ctrl_pkg::*;
#(
    parameter int CW = cpu_ctrl_pkg::CW,
    parameter int RW = cpu_ctrl_pkg::RW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          hold,
    input  logic          clear,
    input  logic [CW-1:0] ctrl_in,
    input  logic [RW-1:0] rd_in,
    output logic [CW-1:0] ctrl_q,
    output logic [RW-1:0] rd_q
);

    logic [CW-1:0] ctrl_d;
    logic [RW-1:0] rd_d;

    always_comb begin
        ctrl_d = ctrl_q;
        rd_d   = rd_q;
        if (!hold) begin
            if (clear) begin
                ctrl_d = '0;
                rd_d   = '0;
            end else begin
                ctrl_d = ctrl_in;
                rd_d   = rd_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q <= '0;
            rd_q   <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            rd_q   <= rd_d;
        end
    end

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control pipeline with load-use detection, flush and stall.
// Define CTRL_PIPE_PERF_EN to build the bubble counter; otherwise bubble_cnt reads 0.
module ctrl_pipe
    import cpu_ctrl_pkg::*;
#(
    parameter int CW = cpu_ctrl_pkg::CW,
    parameter int RW = cpu_ctrl_pkg::RW
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [CW-1:0] ctrl_id,
    input  logic [RW-1:0] rd_id,
    input  logic [RW-1:0] rs1_id,
    input  logic [RW-1:0] rs2_id,
    input  logic          mem_stall,
    input  logic          flush_ex,
    output logic          hazard_stall,
    output logic [CW-1:0] ctrl_ex,
    output logic [CW-1:0] ctrl_mem,
    output logic [CW-1:0] ctrl_wb,
    output logic [RW-1:0] rd_ex,
    output logic [RW-1:0] rd_mem,
    output logic [RW-1:0] rd_wb,
    output logic [31:0]   bubble_cnt
);

    logic [1:0] rw_ex;
    logic       ex_fp;
    logic       ex_writes;
    logic       reads_rs1;
    logic       reads_rs2;
    logic       hit_rs1;
    logic       hit_rs2;
    logic       kill_ex;

    // Integer writes to x0 are discarded, so they cannot feed a dependent instruction.
    assign rw_ex     = ctrl_ex[CTRL_REGWR_HI:CTRL_REGWR_LO];
    assign ex_fp     = ctrl_ex[CTRL_REGWR_HI];
    assign ex_writes = (rw_ex != REGWRITE_NONE) && !(!ex_fp && (rd_ex == '0));

    assign reads_rs1 = (ctrl_id != '0);
    assign reads_rs2 = reads_rs1 && (!ctrl_id[CTRL_ALUSRC] || ctrl_id[CTRL_MEMWRITE]);

    assign hit_rs1 = reads_rs1 && (rd_ex == rs1_id) && (ex_fp == ctrl_id[CTRL_RS1FPU]);
    assign hit_rs2 = reads_rs2 && (rd_ex == rs2_id) && (ex_fp == ctrl_id[CTRL_RS2FPU]);

    assign hazard_stall = ctrl_ex[CTRL_MEMREAD] && ex_writes && (hit_rs1 || hit_rs2);
    assign kill_ex      = flush_ex || hazard_stall;

    ctrl_stage_reg #(.CW(CW), .RW(RW)) u_id_ex (
        .clk     (clk),
        .rstn    (rstn),
        .hold    (mem_stall),
        .clear   (kill_ex),
        .ctrl_in (ctrl_id),
        .rd_in   (rd_id),
        .ctrl_q  (ctrl_ex),
        .rd_q    (rd_ex)
    );

    ctrl_stage_reg #(.CW(CW), .RW(RW)) u_ex_mem (
        .clk     (clk),
        .rstn    (rstn),
        .hold    (mem_stall),
        .clear   (1'b0),
        .ctrl_in (ctrl_ex),
        .rd_in   (rd_ex),
        .ctrl_q  (ctrl_mem),
        .rd_q    (rd_mem)
    );

    ctrl_stage_reg #(.CW(CW), .RW(RW)) u_mem_wb (
        .clk     (clk),
        .rstn    (rstn),
        .hold    (mem_stall),
        .clear   (1'b0),
        .ctrl_in (ctrl_mem),
        .rd_in   (rd_mem),
        .ctrl_q  (ctrl_wb),
        .rd_q    (rd_wb)
    );

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] bubble_cnt_d;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!mem_stall && kill_ex) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = 32'd0;
`endif

endmodule
